// File: rtl/enhanced_pkg.sv
// Shared encodings for the enhanced control unit: opcodes, FSM states,
// accumulator-source selects and the decoded control word.
package enhanced_pkg;

    localparam int unsigned OPC_W    = 3;
    localparam int unsigned ST_ENC_W = 4;
    localparam int unsigned ASEL_W   = 2;

    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    // Encodings 13..15 are unused and recover to S_START.
    typedef enum logic [ST_ENC_W-1:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_FETCH_IR = 4'd2,
        S_DECODE   = 4'd3,
        S_LOAD     = 4'd4,
        S_STORE    = 4'd5,
        S_ADD      = 4'd6,
        S_SUB      = 4'd7,
        S_IN_WAIT  = 4'd8,
        S_IN_REL   = 4'd9,
        S_JZ       = 4'd10,
        S_JPOS     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    localparam logic [ASEL_W-1:0] ASEL_ALU = 2'b00;
    localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
    localparam logic [ASEL_W-1:0] ASEL_MEM = 2'b10;

    typedef struct packed {
        logic              ir_load;
        logic              jmp_mux;
        logic              pc_load;
        logic              mem_inst;
        logic              mem_wr;
        logic              a_load;
        logic              sub;
        logic [ASEL_W-1:0] a_sel;
        logic              halt;
    } ctrl_t;

endpackage

// File: rtl/enhanced_cu_outdec.sv
// State-to-control-word decode; purely combinational, with the input strobe
// and accumulator flags qualifying the IN and jump states.
module enhanced_cu_outdec
    import enhanced_pkg::*;
(
    input  state_e state_i,
    input  logic   enter_i,
    input  logic   aeq0_i,
    input  logic   apos_i,
    output ctrl_t  ctrl_c_o
);

    always_comb begin
        ctrl_c_o = '0;
        case (state_i)
            S_FETCH_IR: begin
                ctrl_c_o.ir_load = 1'b1;
                ctrl_c_o.pc_load = 1'b1;
            end
            S_DECODE: ctrl_c_o.mem_inst = 1'b1;
            S_LOAD: begin
                ctrl_c_o.a_load = 1'b1;
                ctrl_c_o.a_sel  = ASEL_MEM;
            end
            S_STORE: begin
                ctrl_c_o.mem_inst = 1'b1;
                ctrl_c_o.mem_wr   = 1'b1;
            end
            S_ADD: begin
                ctrl_c_o.a_load = 1'b1;
                ctrl_c_o.a_sel  = ASEL_ALU;
            end
            S_SUB: begin
                ctrl_c_o.a_load = 1'b1;
                ctrl_c_o.a_sel  = ASEL_ALU;
                ctrl_c_o.sub    = 1'b1;
            end
            // Load happens in the same cycle the strobe is first seen.
            S_IN_WAIT: begin
                if (enter_i) begin
                    ctrl_c_o.a_load = 1'b1;
                    ctrl_c_o.a_sel  = ASEL_IN;
                end
            end
            S_JZ: begin
                ctrl_c_o.pc_load = aeq0_i;
                ctrl_c_o.jmp_mux = aeq0_i;
            end
            S_JPOS: begin
                ctrl_c_o.pc_load = apos_i;
                ctrl_c_o.jmp_mux = apos_i;
            end
            S_HALT: ctrl_c_o.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/enhanced_cu.sv
// Multi-cycle control unit: fetch / decode / execute sequencer driving the
// accumulator datapath control lines.
module enhanced_cu
    import enhanced_pkg::*;
#(
    parameter int unsigned OP_W = 3,
    parameter int unsigned ST_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] ir,
    input  logic            Aeq0,
    input  logic            Apos,
    input  logic            enter,
    output logic            IRload,
    output logic            JMPmux,
    output logic            PCload,
    output logic            Meminst,
    output logic            MemWr,
    output logic            Aload,
    output logic            sub,
    output logic [1:0]      Asel,
    output logic            halt,
    output logic [ST_W-1:0] state
);

    state_e  state_q;
    state_e  state_d;
    opcode_e op;
    ctrl_t   ctrl_c;

    assign op = opcode_e'(OPC_W'(ir));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to START.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:    state_d = S_FETCH;
            S_FETCH:    state_d = S_FETCH_IR;
            S_FETCH_IR: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_IN:    state_d = S_IN_WAIT;
                    OP_JZ:    state_d = S_JZ;
                    OP_JPOS:  state_d = S_JPOS;
                    OP_HALT:  state_d = S_HALT;
                endcase
            end
            S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_d = S_FETCH;
            S_IN_WAIT: begin
                if (enter) state_d = S_IN_REL;
            end
            // Wait for release so one press loads exactly once.
            S_IN_REL: begin
                if (!enter) state_d = S_FETCH;
            end
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_START;
        endcase
    end

    enhanced_cu_outdec u_outdec (
        .state_i  (state_q),
        .enter_i  (enter),
        .aeq0_i   (Aeq0),
        .apos_i   (Apos),
        .ctrl_c_o (ctrl_c)
    );

    assign IRload  = ctrl_c.ir_load;
    assign JMPmux  = ctrl_c.jmp_mux;
    assign PCload  = ctrl_c.pc_load;
    assign Meminst = ctrl_c.mem_inst;
    assign MemWr   = ctrl_c.mem_wr;
    assign Aload   = ctrl_c.a_load;
    assign sub     = ctrl_c.sub;
    assign Asel    = ctrl_c.a_sel;
    assign halt    = ctrl_c.halt;
    assign state   = ST_W'(state_q);

endmodule

// File: tb/tb_enhanced_cu.sv
// Self-checking bench for enhanced_cu: an instruction-level model expands each
// instruction into its expected per-cycle state/control words.
module tb_enhanced_cu;
    import enhanced_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] ir;
    logic       Aeq0, Apos, enter;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, sub, halt;
    logic [1:0] Asel;
    logic [3:0] state;

    always #5 clock = ~clock;

    enhanced_cu #(.OP_W(3), .ST_W(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .ir      (ir),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .enter   (enter),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Aload   (Aload),
        .sub     (sub),
        .Asel    (Asel),
        .halt    (halt),
        .state   (state)
    );

    // Control word bit order: IRload JMPmux PCload Meminst MemWr Aload sub Asel[1:0] halt
    localparam logic [9:0] C_NONE  = 10'b0000000000;
    localparam logic [9:0] C_FIR   = 10'b1010000000;
    localparam logic [9:0] C_DEC   = 10'b0001000000;
    localparam logic [9:0] C_LOAD  = 10'b0000010100;
    localparam logic [9:0] C_STORE = 10'b0001100000;
    localparam logic [9:0] C_ADD   = 10'b0000010000;
    localparam logic [9:0] C_SUB   = 10'b0000011000;
    localparam logic [9:0] C_JMP   = 10'b0110000000;
    localparam logic [9:0] C_INLD  = 10'b0000010010;
    localparam logic [9:0] C_HALT  = 10'b0000000001;

    typedef struct {
        state_e     st;
        logic [9:0] ctl;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   fails    = 0;
    int   aload_n  = 0;
    int   halt_n   = 0;
    int   memwr_n  = 0;

    // Drive one cycle's inputs just after the edge and queue its expectation.
    task automatic step(input logic rst, input logic [2:0] op, input logic en,
                        input logic a0, input logic ap,
                        input state_e st, input logic [9:0] c);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; ir = op; enter = en; Aeq0 = a0; Apos = ap;
        e.st  = st;
        e.ctl = c;
        q.push_back(e);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic a0, input logic ap,
                             input int n_wait, input int n_press);
        step(1'b1, op, 1'b0, a0, ap, S_FETCH,    C_NONE);
        step(1'b1, op, 1'b0, a0, ap, S_FETCH_IR, C_FIR);
        step(1'b1, op, 1'b0, a0, ap, S_DECODE,   C_DEC);
        case (op)
            3'b000: step(1'b1, op, 1'b0, a0, ap, S_LOAD,  C_LOAD);
            3'b001: step(1'b1, op, 1'b0, a0, ap, S_STORE, C_STORE);
            3'b010: step(1'b1, op, 1'b0, a0, ap, S_ADD,   C_ADD);
            3'b011: step(1'b1, op, 1'b0, a0, ap, S_SUB,   C_SUB);
            3'b100: begin
                for (int i = 0; i < n_wait; i++)
                    step(1'b1, op, 1'b0, a0, ap, S_IN_WAIT, C_NONE);
                step(1'b1, op, 1'b1, a0, ap, S_IN_WAIT, C_INLD);
                for (int i = 1; i < n_press; i++)
                    step(1'b1, op, 1'b1, a0, ap, S_IN_REL, C_NONE);
                step(1'b1, op, 1'b0, a0, ap, S_IN_REL, C_NONE);
            end
            3'b101: step(1'b1, op, 1'b0, a0, ap, S_JZ,   a0 ? C_JMP : C_NONE);
            3'b110: step(1'b1, op, 1'b0, a0, ap, S_JPOS, ap ? C_JMP : C_NONE);
            default: step(1'b1, op, 1'b0, a0, ap, S_HALT, C_HALT);
        endcase
    endtask

    // Single compare process: checks every queued cycle mid-period.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [9:0] act;
            e   = q.pop_front();
            act = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, sub, Asel, halt};
            checks++;
            if (state !== 4'(e.st)) begin
                fails++;
                $display("FAIL state t=%0t actual=%0d required=%0d", $time, state, e.st);
            end
            checks++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL ctrl t=%0t state=%0d actual=%b required=%b",
                         $time, state, act, e.ctl);
            end
            if (Aload === 1'b1) aload_n++;
            if (halt === 1'b1) halt_n++;
            if (MemWr === 1'b1) memwr_n++;
        end
    end

    initial begin
        reset = 1'b0; ir = 3'b000; enter = 1'b0; Aeq0 = 1'b0; Apos = 1'b0;

        // Reset with noisy inputs, then exactly one START cycle before FETCH.
        step(1'b0, 3'b100, 1'b1, 1'b1, 1'b1, S_START, C_NONE);
        step(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, S_START, C_NONE);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_NONE);

        run_instr(3'b010, 1'b0, 1'b0, 0, 0);   // ADD
        run_instr(3'b011, 1'b1, 1'b1, 0, 0);   // SUB
        run_instr(3'b000, 1'b0, 1'b0, 0, 0);   // LOAD
        run_instr(3'b001, 1'b0, 1'b0, 0, 0);   // STORE
        run_instr(3'b100, 1'b0, 1'b0, 5, 3);   // IN: 5 idle, 3 pressed
        run_instr(3'b101, 1'b1, 1'b0, 0, 0);   // JZ taken
        run_instr(3'b101, 1'b0, 1'b1, 0, 0);   // JZ not taken
        run_instr(3'b110, 1'b0, 1'b1, 0, 0);   // JPOS taken
        run_instr(3'b110, 1'b1, 1'b0, 0, 0);   // JPOS not taken
        run_instr(3'b100, 1'b0, 1'b0, 0, 1);   // IN: immediate single-cycle press

        // Reset mid-instruction returns to START, then a clean restart.
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, S_FETCH,    C_NONE);
        step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, S_FETCH_IR, C_FIR);
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, S_START,    C_NONE);

        run_instr(3'b111, 1'b0, 1'b0, 0, 0);   // HALT
        for (int i = 0; i < 20; i++)
            step(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), S_HALT, C_HALT);
        step(1'b0, 3'b000, 1'b1, 1'b1, 1'b1, S_HALT,  C_HALT);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_NONE);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, S_FETCH, C_NONE);

        @(negedge clock);
        #1;

        // Literal pins on the whole run: ADD, SUB, LOAD and two IN loads.
        checks++;
        if (aload_n != 5) begin
            fails++;
            $display("FAIL aload_count actual=%0d required=5", aload_n);
        end
        checks++;
        if (halt_n != 22) begin
            fails++;
            $display("FAIL halt_count actual=%0d required=22", halt_n);
        end
        checks++;
        if (memwr_n != 1) begin
            fails++;
            $display("FAIL memwr_count actual=%0d required=1", memwr_n);
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
